led_pattern_gen: RTL and testbench

Programmable LED pattern engine that turns host register writes into the red/green drive signals for the board LEDs. It sits downstream of the I2C/Wishbone control path. It receives single-cycle decoded write strobes. It produces registered `red`/`green` levels that go straight to the output buffers. It supports off, alternating, synchronous and counted-burst flashing, with a shared prescaler, a programmable half-period and 4-bit PWM brightness.

---
 rtl/led_pattern_gen.sv | 201 ++++++++++++++++++++
 tb/tb_led_pattern_gen.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: turns decoded host register writes into registered red/green
// LED drive. Supports off, alternating, sync and counted-burst flashing, with a
// shared free-running prescaler, a programmable half-period and PWM brightness.
// A MODE write lands in the register file on the strobe edge and is applied to
// the phase generator / state machine one edge later, so the pins follow the
// new mode two edges after the strobe.
module led_pattern_gen #(
    parameter int DIV_W = 20,
    parameter int PWM_W = 4
) (
    input  logic       xclk,
    input  logic       GSRn,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic       red,
    output logic       green,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_MODE   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_DUTY   = 2'd2;
    localparam logic [7:0] PERIOD_RST  = 8'd50;

    // free-running counters
    logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

    // host registers
    logic [1:0]       mode_q, mode_d;
    logic [5:0]       burst_n_q, burst_n_d;
    logic [7:0]       period_q, period_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic             mode_wr_q, mode_wr_d;

    // phase generator and state machine
    logic [7:0] per_cnt_q, per_cnt_d;
    logic       phase_q, phase_d;
    logic [5:0] bcnt_q, bcnt_d;
    state_t     state_q, state_d;

    // registered pins
    logic red_q, red_d;
    logic green_q, green_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic       wr_mode, wr_period, wr_duty;
    logic       tick;
    logic [7:0] per_eff;
    logic       pwm_on;
    logic       burst_done;
    logic       lit;
    logic       bursts_left;

    assign wr_mode   = cfg_wr && (cfg_addr == ADDR_MODE);
    assign wr_period = cfg_wr && (cfg_addr == ADDR_PERIOD);
    assign wr_duty   = cfg_wr && (cfg_addr == ADDR_DUTY);

    assign tick    = &pre_cnt_q;
    assign per_eff = (period_q == 8'd0) ? 8'd1 : period_q;
    assign pwm_on  = (pwm_cnt_q < duty_q);

    // A burst finishes once the completed on-phase count matches the target.
    // Any MODE write already in flight (this cycle or being applied) takes
    // priority, so completion and its done pulse are suppressed.
    assign burst_done = (state_q == ST_BURST) && (bcnt_q == burst_n_q)
                        && !wr_mode && !mode_wr_q;

    // Prescaler and PWM counters simply wrap; only GSRn clears them.
    always_comb begin
        pre_cnt_d = pre_cnt_q + DIV_W'(1);
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    end

    // Register file: host writes, plus mode falling back to 0 after a burst.
    always_comb begin
        mode_d    = mode_q;
        burst_n_d = burst_n_q;
        period_d  = period_q;
        duty_d    = duty_q;
        mode_wr_d = wr_mode;
        if (wr_mode) begin
            mode_d    = cfg_data[1:0];
            burst_n_d = cfg_data[7:2];
        end else if (burst_done) begin
            mode_d = 2'd0;
        end
        if (wr_period) period_d = cfg_data;
        if (wr_duty)   duty_d   = cfg_data[PWM_W-1:0];
    end

    // Phase generator and OFF/RUN/BURST sequencing. Applying a MODE write
    // restarts the half-period with the LED phase on.
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        phase_d   = phase_q;
        bcnt_d    = bcnt_q;
        if (mode_wr_q) begin
            per_cnt_d = 8'd0;
            phase_d   = 1'b1;
            bcnt_d    = 6'd0;
            case (mode_q)
                2'd0:    state_d = ST_OFF;
                2'd3:    state_d = ST_BURST;
                default: state_d = ST_RUN;
            endcase
        end else begin
            if (tick) begin
                // >= so that shrinking PERIOD below the running count
                // toggles on the very next tick instead of wrapping.
                if (per_cnt_q >= (per_eff - 8'd1)) begin
                    per_cnt_d = 8'd0;
                    phase_d   = ~phase_q;
                    if ((state_q == ST_BURST) && phase_q)
                        bcnt_d = bcnt_q + 6'd1;
                end else begin
                    per_cnt_d = per_cnt_q + 8'd1;
                end
            end
            if (burst_done) state_d = ST_OFF;
        end
    end

    // Pin values are computed from next-state values and registered.
    always_comb begin
        lit         = phase_d & pwm_on;
        // Keeps a zero-length burst dark on its single entry cycle.
        bursts_left = (bcnt_d != burst_n_q);
        red_d       = 1'b0;
        green_d     = 1'b0;
        busy_d      = (state_d != ST_OFF);
        done_d      = burst_done;
        case (state_d)
            ST_RUN: begin
                red_d   = lit;
                green_d = (mode_q == 2'd1) ? (~phase_d & pwm_on) : lit;
            end
            ST_BURST: begin
                red_d   = lit & bursts_left;
                green_d = lit & bursts_left;
            end
            default: begin
                red_d   = 1'b0;
                green_d = 1'b0;
            end
        endcase
    end

    // All state, asynchronously cleared by GSRn.
    always_ff @(posedge xclk or negedge GSRn) begin
        if (!GSRn) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
            mode_q    <= 2'd0;
            burst_n_q <= 6'd0;
            period_q  <= PERIOD_RST;
            duty_q    <= '1;
            mode_wr_q <= 1'b0;
            per_cnt_q <= 8'd0;
            phase_q   <= 1'b0;
            bcnt_q    <= 6'd0;
            state_q   <= ST_OFF;
            red_q     <= 1'b0;
            green_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            mode_q    <= mode_d;
            burst_n_q <= burst_n_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            mode_wr_q <= mode_wr_d;
            per_cnt_q <= per_cnt_d;
            phase_q   <= phase_d;
            bcnt_q    <= bcnt_d;
            state_q   <= state_d;
            red_q     <= red_d;
            green_q   <= green_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen with DIV_W=4, PWM_W=4: one tick every 16 clocks,
// PWM period 16 clocks. Expectations come from the behavioural rules
// (interval lengths, pulse counts, lit-cycle totals over whole periods).
module tb_led_pattern_gen;

    localparam int DIV_W = 4;
    localparam int PWM_W = 4;

    logic       xclk = 1'b0;
    logic       GSRn = 1'b1;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_data = 8'd0;
    logic       red, green, busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;   // clock edges since reset release = prescaler value mod 16

    led_pattern_gen #(.DIV_W(DIV_W), .PWM_W(PWM_W)) dut (
        .xclk(xclk), .GSRn(GSRn), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .red(red), .green(green), .busy(busy), .done(done)
    );

    always #5 xclk = ~xclk;

    always @(posedge xclk or negedge GSRn)
        if (!GSRn) cyc <= 0;
        else       cyc <= cyc + 1;

    task automatic step();
        @(posedge xclk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        step();
        cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0;
    endtask

    // next strobe is sampled on the edge where cyc becomes r+1 (mod 16)
    task automatic align(input int r);
        while ((cyc % 16) != r) step();
    endtask

    task automatic test_reset();
        int act;
        #2 GSRn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_wr = 1'($urandom); cfg_addr = 2'($urandom); cfg_data = 8'($urandom);
            step();
            total++;
            if ({red, green, busy, done} !== 4'b0) begin
                bad++;
                $display("FAIL reset_hold: got %b want 0000", {red, green, busy, done});
            end
        end
        @(negedge xclk);
        cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0;
        GSRn = 1'b1;
        step();
        wr(2'd1, 8'd3);
        wr(2'd2, 8'd7);
        act = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (red || green || busy || done) act++;
        end
        total++;
        if (act !== 0) begin
            bad++;
            $display("FAIL reset_idle: got %0d active cycles want 0", act);
        end
    endtask

    task automatic test_alt(input int p);
        int ident, first_ident, nchg, last_chg, first_chg, both, notbusy, bad_iv;
        ident = 0; first_ident = 0; nchg = 0; last_chg = 0; first_chg = 0;
        both = 0; notbusy = 0; bad_iv = 0;
        wr(2'd1, 8'(p));
        wr(2'd2, 8'd15);
        wr(2'd0, 8'h01);
        for (int i = 1; i <= 16 * p * 5 + 40; i++) begin
            step();
            if (red && green) both++;
            if (!busy) notbusy++;
            if (red ^ green) begin
                if (first_ident == 0) first_ident = red ? 1 : 2;
                else if ((red ? 1 : 2) != ident) begin
                    nchg++;
                    if (nchg == 1) first_chg = i;
                    else if ((i - last_chg) != 16 * p) bad_iv++;
                    last_chg = i;
                end
                ident = red ? 1 : 2;
            end
        end
        total++;
        if (both !== 0) begin bad++; $display("FAIL alt_exclusive: got %0d overlap cycles want 0", both); end
        total++;
        if (notbusy !== 0) begin bad++; $display("FAIL alt_busy: got %0d idle cycles want 0", notbusy); end
        total++;
        if (first_ident !== 1) begin bad++; $display("FAIL alt_first_red: got %0d want 1", first_ident); end
        total++;
        if (first_chg < 16 * (p - 1) + 1 || first_chg > 16 * p + 2) begin
            bad++;
            $display("FAIL alt_first_interval: got %0d want %0d..%0d", first_chg, 16 * (p - 1) + 1, 16 * p + 2);
        end
        total++;
        if (nchg < 4) begin bad++; $display("FAIL alt_changes: got %0d want >=4", nchg); end
        total++;
        if (bad_iv !== 0) begin bad++; $display("FAIL alt_interval p=%0d: got %0d bad intervals want 0", p, bad_iv); end
        wr(2'd0, 8'h00);
        repeat (3) step();
    endtask

    task automatic test_sync(input int d);
        int lit, diff, badrun, run, skip, notbusy, r;
        r = $urandom;
        wr(2'd1, 8'd4);
        wr(2'd2, 8'(d));
        wr(2'd0, 8'h02);
        // register 3 must be inert whatever the data
        wr(2'd3, 8'((r & 32'hF0) | ((d == 0) ? 8 : 0)));
        repeat (80) step();
        lit = 0; diff = 0; badrun = 0; run = 0; skip = red ? 1 : 0; notbusy = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (red !== green) diff++;
            if (!busy) notbusy++;
            if (red) begin
                lit++; run++;
            end else begin
                if (run != 0 && skip == 0 && run != d) badrun++;
                run = 0; skip = 0;
            end
        end
        total++;
        if (lit !== 8 * d) begin bad++; $display("FAIL sync_lit d=%0d: got %0d want %0d", d, lit, 8 * d); end
        total++;
        if (diff !== 0) begin bad++; $display("FAIL sync_equal: got %0d differing cycles want 0", diff); end
        total++;
        if (badrun !== 0) begin bad++; $display("FAIL sync_pwm_run d=%0d: got %0d bad runs want 0", d, badrun); end
        total++;
        if (notbusy !== 0) begin bad++; $display("FAIL sync_busy: got %0d idle cycles want 0", notbusy); end
        wr(2'd0, 8'h00);
        repeat (3) step();
    endtask

    task automatic test_burst(input int n);
        int runs, runlen, badlen, ndone, done_at, badedge, after, diff, busy1;
        logic prev_red, prev_busy;
        runs = 0; runlen = 0; badlen = 0; ndone = 0; done_at = -1;
        badedge = 0; after = 0; diff = 0; busy1 = 0;
        wr(2'd1, 8'd1);
        wr(2'd2, 8'd15);
        align(3);
        wr(2'd0, 8'((n << 2) | 3));
        prev_red = red; prev_busy = busy;
        for (int i = 1; i <= 32 * n + 60; i++) begin
            step();
            if (i == 1) busy1 = busy ? 1 : 0;
            if (red !== green) diff++;
            if (red && !prev_red) begin runs++; runlen = 0; end
            if (red) runlen++;
            if (!red && prev_red)
                if (runlen < 1 || runlen > 16 || (runs > 1 && runlen != 15)) badlen++;
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = i;
                    if (busy || !prev_busy) badedge++;
                end
            end
            if (done_at >= 0 && (red || green || busy)) after++;
            prev_red = red; prev_busy = busy;
        end
        total++;
        if (runs !== n) begin bad++; $display("FAIL burst_pulses n=%0d: got %0d want %0d", n, runs, n); end
        total++;
        if (ndone !== 1) begin bad++; $display("FAIL burst_done_count n=%0d: got %0d want 1", n, ndone); end
        total++;
        if (badedge !== 0) begin bad++; $display("FAIL burst_done_busy_edge: got %0d want 0", badedge); end
        total++;
        if (after !== 0) begin bad++; $display("FAIL burst_quiet_after: got %0d active cycles want 0", after); end
        total++;
        if (diff !== 0) begin bad++; $display("FAIL burst_equal: got %0d differing cycles want 0", diff); end
        total++;
        if (badlen !== 0) begin bad++; $display("FAIL burst_pulse_len: got %0d bad pulses want 0", badlen); end
        if (n == 0) begin
            total++;
            if (done_at !== 2) begin bad++; $display("FAIL burst0_done_time: got %0d want 2", done_at); end
            total++;
            if (busy1 !== 1) begin bad++; $display("FAIL burst0_busy: got %0d want 1", busy1); end
        end
    endtask

    task automatic test_collision();
        int ndone, notbusy, sr, sg;
        ndone = 0; notbusy = 0; sr = 0; sg = 0;
        wr(2'd1, 8'd1);
        wr(2'd2, 8'd15);
        align(3);
        wr(2'd0, 8'h07);   // one-pulse burst
        // the single on-phase ends at the next tick; completion is due one edge later
        repeat (12) begin
            step();
            if (done) ndone++;
            if (!busy) notbusy++;
        end
        wr(2'd0, 8'h01);
        if (done) ndone++;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done) ndone++;
            if (!busy) notbusy++;
            if (red && !green) sr = 1;
            if (green && !red) sg = 1;
        end
        total++;
        if (ndone !== 0) begin bad++; $display("FAIL collision_done: got %0d pulses want 0", ndone); end
        total++;
        if (notbusy !== 0) begin bad++; $display("FAIL collision_busy: got %0d idle cycles want 0", notbusy); end
        total++;
        if ((sr + sg) !== 2) begin bad++; $display("FAIL collision_alternating: got %0d colours want 2", sr + sg); end
        wr(2'd0, 8'h00);
        repeat (3) step();
    endtask

    task automatic test_period_shrink();
        int dr, maxd1, maxd2;
        wr(2'd2, 8'd15);
        wr(2'd1, 8'd200);
        wr(2'd0, 8'h02);
        dr = 0; maxd1 = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (!red) dr++; else dr = 0;
            if (dr > maxd1) maxd1 = dr;
        end
        wr(2'd1, 8'd1);
        dr = 0; maxd2 = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!red) dr++; else dr = 0;
            if (dr > maxd2) maxd2 = dr;
        end
        total++;
        if (maxd1 > 1) begin bad++; $display("FAIL period_long_hold: got %0d dark run want <=1", maxd1); end
        total++;
        if (maxd2 < 16) begin bad++; $display("FAIL period_shrink_toggle: got %0d dark run want >=16", maxd2); end
        wr(2'd0, 8'h00);
        repeat (3) step();
    endtask

    task automatic test_async_reset();
        int runs, found, lit, diff, notbusy;
        logic prev;
        runs = 0; found = 0; prev = red;
        wr(2'd1, 8'd1);
        wr(2'd2, 8'd15);
        wr(2'd0, 8'h17);   // five-pulse burst
        for (int i = 0; i < 200 && found == 0; i++) begin
            step();
            if (red && !prev) runs++;
            prev = red;
            if (runs == 2) found = 1;
        end
        repeat (4) step();
        total++;
        if (red !== 1'b1) begin bad++; $display("FAIL async_in_pulse: got %0d want 1", red); end
        #3 GSRn = 1'b0;
        #1;
        total++;
        if ({red, green, busy, done} !== 4'b0) begin
            bad++;
            $display("FAIL async_clear: got %b want 0000", {red, green, busy, done});
        end
        repeat (3) @(negedge xclk);
        GSRn = 1'b1;
        step();
        step();
        wr(2'd0, 8'h02);
        repeat (20) step();
        lit = 0; diff = 0; notbusy = 0;
        for (int i = 0; i < 288; i++) begin
            step();
            if (red) lit++;
            if (red !== green) diff++;
            if (!busy) notbusy++;
        end
        total++;
        if (lit !== 270) begin bad++; $display("FAIL async_defaults_lit: got %0d want 270", lit); end
        total++;
        if (diff !== 0) begin bad++; $display("FAIL async_defaults_equal: got %0d want 0", diff); end
        total++;
        if (notbusy !== 0) begin bad++; $display("FAIL async_defaults_busy: got %0d want 0", notbusy); end
    endtask

    initial begin
        test_reset();
        test_alt(2);
        test_alt($urandom_range(1, 4));
        test_sync(4);
        test_sync($urandom_range(1, 15));
        test_sync(0);
        test_burst(3);
        test_burst(0);
        test_burst($urandom_range(1, 4));
        test_collision();
        test_period_shrink();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
